// File: rtl/text_console_if.sv
// Byte-stream input and character write port of the text console sequencer.
// master = byte source / glyph sink side, slave = text_console_ctrl.
interface text_console_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_attr;
  logic [6:0] char_x;
  logic [5:0] char_y;
  logic [8:0] char_chr;
  logic       char_str;

  modport master (
    output in_valid, in_data, in_attr,
    input  in_ready, char_x, char_y, char_chr, char_str
  );

  modport slave (
    input  in_valid, in_data, in_attr,
    output in_ready, char_x, char_y, char_chr, char_str
  );
endinterface

// File: rtl/text_console_ctrl.sv
// Cursor-tracking sequencer turning a byte stream into textmode character writes.
// Optional macro CONSOLE_AUTOWRAP_EN: wrap to a cleared new line past the last column.
module text_console_ctrl #(
  parameter int unsigned COLS      = 80,
  parameter int unsigned ROWS      = 30,
  parameter logic [8:0]  BLANK_CHR = 9'h020
) (
  input  logic          clk_sys,
  input  logic          reset,
  text_console_if.slave bus,
  output logic [6:0]    cursor_x,
  output logic [5:0]    cursor_y,
  output logic          busy
);

  localparam logic [6:0] X_LAST  = 7'(COLS - 1);
  localparam logic [5:0] Y_LAST  = 6'(ROWS - 1);
  localparam logic [7:0] X_LIMIT = 8'(COLS);

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_TAB = 8'h09;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_FF  = 8'h0C;
  localparam logic [7:0] CH_CR  = 8'h0D;

  // ST_WRITE is the single cycle in which the last issued strobe sits on the port.
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_LINECLR, ST_SCRCLR} state_e;

  state_e     state_q, state_d;
  logic [6:0] cur_x_q, cur_x_d, clr_x_q, clr_x_d;
  logic [5:0] cur_y_q, cur_y_d, clr_y_q, clr_y_d;
  logic       str_q, str_d;
  logic [6:0] wx_q, wx_d;
  logic [5:0] wy_q, wy_d;
  logic [8:0] chr_q, chr_d;
  logic       ready_q, busy_q;

  logic       accept, printable, do_newline;
  logic [5:0] next_row;
  logic [7:0] tab_nx;

  assign accept    = bus.in_valid && ready_q;
  assign printable = (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E);
  assign next_row  = (cur_y_q == Y_LAST) ? 6'd0 : cur_y_q + 6'd1;
  assign tab_nx    = {1'b0, cur_x_q & 7'h78} + 8'd8;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ST_SCRCLR;
      cur_x_q <= '0;
      cur_y_q <= '0;
      clr_x_q <= '0;
      clr_y_q <= '0;
      str_q   <= 1'b0;
      wx_q    <= '0;
      wy_q    <= '0;
      chr_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      clr_x_q <= clr_x_d;
      clr_y_q <= clr_y_d;
      str_q   <= str_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      chr_q   <= chr_d;
      ready_q <= (state_d == ST_IDLE);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    state_d    = state_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    clr_x_d    = clr_x_q;
    clr_y_d    = clr_y_q;
    do_newline = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WRITE;
          if (printable) begin
            if (cur_x_q != X_LAST) cur_x_d = cur_x_q + 7'd1;
`ifdef CONSOLE_AUTOWRAP_EN
            else do_newline = 1'b1;
`endif
          end else begin
            case (bus.in_data)
              CH_LF:  do_newline = 1'b1;
              CH_CR:  cur_x_d = 7'd0;
              CH_BS:  if (cur_x_q != 7'd0) cur_x_d = cur_x_q - 7'd1;
              CH_TAB: begin
                if (tab_nx < X_LIMIT) cur_x_d = tab_nx[6:0];
`ifdef CONSOLE_AUTOWRAP_EN
                else do_newline = 1'b1;
`else
                else cur_x_d = X_LAST;
`endif
              end
              CH_FF: begin
                cur_x_d = 7'd0;
                cur_y_d = 6'd0;
                state_d = ST_SCRCLR;
              end
              default: ;
            endcase
          end
          if (do_newline) begin
            cur_x_d = 7'd0;
            cur_y_d = next_row;
            state_d = ST_LINECLR;
          end
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_LINECLR: begin
        if (clr_x_q == X_LAST) begin
          clr_x_d = 7'd0;
          state_d = ST_WRITE;
        end else begin
          clr_x_d = clr_x_q + 7'd1;
        end
      end
      ST_SCRCLR: begin
        if (clr_x_q == X_LAST) begin
          clr_x_d = 7'd0;
          if (clr_y_q == Y_LAST) begin
            clr_y_d = 6'd0;
            cur_x_d = 7'd0;
            cur_y_d = 6'd0;
            state_d = ST_WRITE;
          end else begin
            clr_y_d = clr_y_q + 6'd1;
          end
        end else begin
          clr_x_d = clr_x_q + 7'd1;
        end
      end
      default: state_d = ST_SCRCLR;
    endcase
  end

  // Write port contents for the next cycle; coordinates hold while no strobe is issued.
  always_comb begin
    str_d = 1'b0;
    wx_d  = wx_q;
    wy_d  = wy_q;
    chr_d = chr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (printable) begin
            str_d = 1'b1;
            wx_d  = cur_x_q;
            wy_d  = cur_y_q;
            chr_d = {bus.in_attr, bus.in_data};
          end else if (bus.in_data == CH_BS && cur_x_q != 7'd0) begin
            str_d = 1'b1;
            wx_d  = cur_x_q - 7'd1;
            wy_d  = cur_y_q;
            chr_d = BLANK_CHR;
          end
        end
      end
      ST_LINECLR: begin
        str_d = 1'b1;
        wx_d  = clr_x_q;
        wy_d  = cur_y_q;
        chr_d = BLANK_CHR;
      end
      ST_SCRCLR: begin
        str_d = 1'b1;
        wx_d  = clr_x_q;
        wy_d  = clr_y_q;
        chr_d = BLANK_CHR;
      end
      default: ;
    endcase
  end

  assign bus.in_ready = ready_q;
  assign bus.char_str = str_q;
  assign bus.char_x   = wx_q;
  assign bus.char_y   = wy_q;
  assign bus.char_chr = chr_q;
  assign cursor_x     = cur_x_q;
  assign cursor_y     = cur_y_q;
  assign busy         = busy_q;

endmodule
